// File: rtl/spi_txn_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_txn_arbiter: shares one spi_controller between a priority host port (A)
// and an accelerometer poller (B) with starvation limit and timeout. Rev 1.0
// ---------------------------------------------------------------------------
module spi_txn_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 1023,
  parameter int TO_W       = 10
) (
  input  logic        iRSTN,
  input  logic        iSPI_CLK,
  input  logic        iA_REQ,
  input  logic        iA_RNW,
  input  logic [5:0]  iA_ADDR,
  input  logic [7:0]  iA_WDATA,
  output logic        oA_ACK,
  input  logic        iB_REQ,
  input  logic        iB_RNW,
  input  logic [5:0]  iB_ADDR,
  input  logic [7:0]  iB_WDATA,
  output logic        oB_ACK,
  output logic        oERR,
  output logic [7:0]  oRDATA,
  output logic [15:0] oP2S_DATA,
  output logic        oSPI_GO,
  input  logic        iSPI_END,
  input  logic [7:0]  iS2P_DATA,
  output logic        oBUSY
);

  localparam int SC_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t          state;
  logic [SC_W-1:0] starve_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            cur_b;

  logic            grant_b;
  logic [15:0]     cmd_a;
  logic [15:0]     cmd_b;

  // B wins outright when alone, or when A has used up its starvation allowance.
  assign grant_b = iB_REQ && (!iA_REQ || (starve_cnt == SC_W'(STARVE_MAX)));
  assign cmd_a   = {iA_RNW, 1'b0, iA_ADDR, (iA_RNW ? 8'h00 : iA_WDATA)};
  assign cmd_b   = {iB_RNW, 1'b0, iB_ADDR, (iB_RNW ? 8'h00 : iB_WDATA)};
  assign oBUSY   = (state != S_IDLE);

  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state      <= S_IDLE;
      starve_cnt <= '0;
      to_cnt     <= '0;
      cur_b      <= 1'b0;
      oSPI_GO    <= 1'b0;
      oP2S_DATA  <= 16'h0000;
      oA_ACK     <= 1'b0;
      oB_ACK     <= 1'b0;
      oERR       <= 1'b0;
      oRDATA     <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (iA_REQ || iB_REQ) begin
            state     <= S_WAIT;
            oSPI_GO   <= 1'b1;
            cur_b     <= grant_b;
            oP2S_DATA <= grant_b ? cmd_b : cmd_a;
            if (grant_b || !iB_REQ) begin
              starve_cnt <= '0;
            end else if (starve_cnt != SC_W'(STARVE_MAX)) begin
              starve_cnt <= starve_cnt + SC_W'(1);
            end
          end
        end
        S_WAIT: begin
          // A real end on the timeout edge takes precedence over the abort.
          if (iSPI_END) begin
            state   <= S_ACK;
            oSPI_GO <= 1'b0;
            oRDATA  <= oP2S_DATA[15] ? iS2P_DATA : 8'h00;
            oA_ACK  <= !cur_b;
            oB_ACK  <= cur_b;
            oERR    <= 1'b0;
          end else if (to_cnt == TO_W'(TIMEOUT)) begin
            state   <= S_ACK;
            oSPI_GO <= 1'b0;
            oRDATA  <= 8'hFF;
            oA_ACK  <= !cur_b;
            oB_ACK  <= cur_b;
            oERR    <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        S_ACK: begin
          state  <= S_IDLE;
          oA_ACK <= 1'b0;
          oB_ACK <= 1'b0;
          oERR   <= 1'b0;
          to_cnt <= '0;
        end
        default: begin
          state   <= S_IDLE;
          oSPI_GO <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_txn_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_spi_txn_arbiter: randomized bench with a behavioural arbitration model.
// ---------------------------------------------------------------------------
module tb_spi_txn_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 1023;

  logic        iRSTN, iSPI_CLK;
  logic        iA_REQ, iA_RNW, iB_REQ, iB_RNW;
  logic [5:0]  iA_ADDR, iB_ADDR;
  logic [7:0]  iA_WDATA, iB_WDATA, iS2P_DATA;
  logic        iSPI_END;
  logic        oA_ACK, oB_ACK, oERR, oSPI_GO, oBUSY;
  logic [7:0]  oRDATA;
  logic [15:0] oP2S_DATA;

  int n_cmp = 0;
  int n_bad = 0;
  int starve_m = 0;

  spi_txn_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT), .TO_W(10)) dut (
    .iRSTN(iRSTN), .iSPI_CLK(iSPI_CLK),
    .iA_REQ(iA_REQ), .iA_RNW(iA_RNW), .iA_ADDR(iA_ADDR), .iA_WDATA(iA_WDATA), .oA_ACK(oA_ACK),
    .iB_REQ(iB_REQ), .iB_RNW(iB_RNW), .iB_ADDR(iB_ADDR), .iB_WDATA(iB_WDATA), .oB_ACK(oB_ACK),
    .oERR(oERR), .oRDATA(oRDATA), .oP2S_DATA(oP2S_DATA), .oSPI_GO(oSPI_GO),
    .iSPI_END(iSPI_END), .iS2P_DATA(iS2P_DATA), .oBUSY(oBUSY)
  );

  initial iSPI_CLK = 1'b0;
  always #5 iSPI_CLK = ~iSPI_CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] word(input logic rnw, input logic [5:0] a, input logic [7:0] d);
    return (rnw ? 16'h8000 : 16'h0000) + {2'b00, a, 8'h00} + (rnw ? 16'h0000 : {8'h00, d});
  endfunction

  // Arbitration rule from the current requests; advances the starvation model.
  task automatic pick(output bit b);
    b = iB_REQ && (!iA_REQ || starve_m >= STARVE_MAX);
    if (b || !iB_REQ) starve_m = 0;
    else if (starve_m < STARVE_MAX) starve_m++;
  endtask

  // Entered at a negedge in IDLE with requests already driven.
  task automatic transfer(input string tag, input int len, input logic [7:0] s2p,
                          input bit drop_win, input logic [1:0] drop, output bit got_b);
    bit eb;
    logic ernw;
    logic [15:0] ew;
    pick(eb);
    ernw = eb ? iB_RNW : iA_RNW;
    ew   = eb ? word(iB_RNW, iB_ADDR, iB_WDATA) : word(iA_RNW, iA_ADDR, iA_WDATA);
    @(negedge iSPI_CLK);
    check({tag, ".go"}, oSPI_GO, 1);
    check({tag, ".p2s"}, oP2S_DATA, ew);
    check({tag, ".busy"}, oBUSY, 1);
    repeat (len) @(negedge iSPI_CLK);
    check({tag, ".go_hold"}, oSPI_GO, 1);
    check({tag, ".p2s_hold"}, oP2S_DATA, ew);
    iSPI_END  = 1'b1;
    iS2P_DATA = s2p;
    @(negedge iSPI_CLK);
    got_b = oB_ACK;
    check({tag, ".a_ack"}, oA_ACK, !eb);
    check({tag, ".b_ack"}, oB_ACK, eb);
    check({tag, ".rdata"}, oRDATA, ernw ? s2p : 8'h00);
    check({tag, ".err"}, oERR, 0);
    check({tag, ".go_low1"}, oSPI_GO, 0);
    iSPI_END  = 1'b0;
    iS2P_DATA = 8'($urandom);
    if (drop_win) begin
      if (eb) iB_REQ = 1'b0;
      else iA_REQ = 1'b0;
    end
    if (drop[0]) iA_REQ = 1'b0;
    if (drop[1]) iB_REQ = 1'b0;
    @(negedge iSPI_CLK);
    check({tag, ".ack_pulse"}, {oA_ACK, oB_ACK, oERR}, 0);
    check({tag, ".go_low2"}, oSPI_GO, 0);
    check({tag, ".rdata_keep"}, oRDATA, ernw ? s2p : 8'h00);
  endtask

  // Port A read that either hangs to timeout or ends exactly on the timeout edge.
  task automatic timeout_txn(input string tag, input bit coincide, input logic [7:0] s2p);
    bit eb;
    pick(eb);
    @(negedge iSPI_CLK);
    check({tag, ".go"}, oSPI_GO, 1);
    repeat (TIMEOUT) @(negedge iSPI_CLK);
    check({tag, ".go_wait"}, oSPI_GO, 1);
    check({tag, ".no_ack"}, oA_ACK, 0);
    if (coincide) begin
      iSPI_END  = 1'b1;
      iS2P_DATA = s2p;
    end
    @(negedge iSPI_CLK);
    check({tag, ".a_ack"}, oA_ACK, 1);
    check({tag, ".err"}, oERR, !coincide);
    check({tag, ".rdata"}, oRDATA, coincide ? s2p : 8'hFF);
    check({tag, ".go_drop"}, oSPI_GO, 0);
    iSPI_END = 1'b0;
    iA_REQ   = 1'b0;
    @(negedge iSPI_CLK);
    check({tag, ".clear"}, {oA_ACK, oERR}, 0);
  endtask

  initial begin
    bit gb;
    iRSTN = 1'b0; iA_REQ = 0; iA_RNW = 0; iA_ADDR = 0; iA_WDATA = 0;
    iB_REQ = 0; iB_RNW = 0; iB_ADDR = 0; iB_WDATA = 0; iSPI_END = 0; iS2P_DATA = 0;
    repeat (3) @(negedge iSPI_CLK);
    check("rst.go", oSPI_GO, 0);
    check("rst.p2s", oP2S_DATA, 0);
    check("rst.acks", {oA_ACK, oB_ACK, oERR}, 0);
    check("rst.rdata", oRDATA, 0);
    check("rst.busy", oBUSY, 0);
    iRSTN = 1'b1;

    // A read of address 0x00 returning the device ID.
    iA_REQ = 1; iA_RNW = 1; iA_ADDR = 6'h00; iA_WDATA = 8'h5A;
    transfer("a_rd", 20, 8'hE5, 1, 2'b00, gb);

    // B write POWER_CTL.
    iB_REQ = 1; iB_RNW = 0; iB_ADDR = 6'h2D; iB_WDATA = 8'h08;
    transfer("b_wr", 12, 8'h77, 1, 2'b00, gb);
    check("b_wr.idle_go", oSPI_GO, 0);

    // Both held continuously: B every fifth grant.
    iA_REQ = 1; iA_RNW = 0; iA_ADDR = 6'h31; iA_WDATA = 8'h0B;
    iB_REQ = 1; iB_RNW = 1; iB_ADDR = 6'h32; iB_WDATA = 8'hC3;
    for (int i = 0; i < 10; i++) begin
      transfer("both", 3 + i, 8'(8'h40 + i), 0, (i == 9) ? 2'b11 : 2'b00, gb);
      check("both.order", gb, (i % 5) == 4);
    end

    // Hung transfer, then a normal one.
    iA_REQ = 1; iA_RNW = 1; iA_ADDR = 6'h30;
    timeout_txn("tmo", 0, 8'h00);
    iA_REQ = 1; iA_RNW = 1; iA_ADDR = 6'h30;
    transfer("tmo_next", 5, 8'h83, 1, 2'b00, gb);

    // End arrives on the very edge the timeout fires.
    iA_REQ = 1; iA_RNW = 1; iA_ADDR = 6'h36;
    timeout_txn("tmo_end", 1, 8'h9C);

    // Reset in the middle of WAIT.
    iA_REQ = 1; iA_RNW = 0; iA_ADDR = 6'h2C; iA_WDATA = 8'h0A;
    @(negedge iSPI_CLK);
    repeat (3) @(negedge iSPI_CLK);
    #2 iRSTN = 1'b0;
    #1;
    check("rst_mid.go", oSPI_GO, 0);
    check("rst_mid.acks", {oA_ACK, oB_ACK, oERR}, 0);
    check("rst_mid.busy", oBUSY, 0);
    starve_m = 0;
    @(negedge iSPI_CLK);
    check("rst_mid.no_ack", {oA_ACK, oB_ACK}, 0);
    iRSTN = 1'b1;
    transfer("rst_after", 4, 8'h11, 1, 2'b00, gb);

    // Randomized mix; a pending requester keeps its command stable.
    for (int i = 0; i < 40; i++) begin
      if (!iA_REQ && ($urandom_range(0, 1) == 1)) begin
        iA_REQ = 1; iA_RNW = 1'($urandom); iA_ADDR = 6'($urandom); iA_WDATA = 8'($urandom);
      end
      if (!iB_REQ && ($urandom_range(0, 2) != 0)) begin
        iB_REQ = 1; iB_RNW = 1'($urandom); iB_ADDR = 6'($urandom); iB_WDATA = 8'($urandom);
      end
      if (!iA_REQ && !iB_REQ) begin
        iA_REQ = 1; iA_RNW = 1'($urandom); iA_ADDR = 6'($urandom); iA_WDATA = 8'($urandom);
      end
      transfer("rnd", $urandom_range(1, 25), 8'($urandom), 1, 2'b00, gb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
